// File: rtl/barrel_thread_sched_if.sv
// barrel_thread_sched_if
//   Bundles the scheduler's control and issue signals.
//   slave  : scheduler side (samples enables/redirects, drives issue/writeback).
//   master : environment side (drives enables/redirects, observes issue/writeback).
//   Inputs : thread_en, redirect_valid/tid/pc
//            (+ halt_valid/tid, resume_valid/tid when BARREL_THREAD_HALT_EN)
//   Outputs: issue_valid/tid/pc, tid_read, tid_write, wb_valid, active_mask
interface barrel_thread_sched_if #(
    parameter int unsigned NUM_THREADS = 8,
    parameter int unsigned ADDR_WIDTH  = 32
);
    localparam int unsigned TW = $clog2(NUM_THREADS);

    logic [NUM_THREADS-1:0] thread_en;
    logic                   redirect_valid;
    logic [TW-1:0]          redirect_tid;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
`ifdef BARREL_THREAD_HALT_EN
    logic                   halt_valid;
    logic [TW-1:0]          halt_tid;
    logic                   resume_valid;
    logic [TW-1:0]          resume_tid;
`endif
    logic                   issue_valid;
    logic [TW-1:0]          issue_tid;
    logic [ADDR_WIDTH-1:0]  issue_pc;
    logic [TW-1:0]          tid_read;
    logic [TW-1:0]          tid_write;
    logic                   wb_valid;
    logic [NUM_THREADS-1:0] active_mask;

    modport slave (
`ifdef BARREL_THREAD_HALT_EN
        input  halt_valid, halt_tid, resume_valid, resume_tid,
`endif
        input  thread_en, redirect_valid, redirect_tid, redirect_pc,
        output issue_valid, issue_tid, issue_pc, tid_read, tid_write, wb_valid, active_mask
    );

    modport master (
`ifdef BARREL_THREAD_HALT_EN
        output halt_valid, halt_tid, resume_valid, resume_tid,
`endif
        output thread_en, redirect_valid, redirect_tid, redirect_pc,
        input  issue_valid, issue_tid, issue_pc, tid_read, tid_write, wb_valid, active_mask
    );
endinterface

// File: rtl/barrel_thread_sched.sv
// barrel_thread_sched
//   Round-robin hardware-thread scheduler for the barrel core. Each cycle it
//   picks the next runnable thread after the last issued one, issues its PC,
//   advances that PC by 4, and delays {valid,tid} by PIPE_DEPTH cycles for
//   writeback. Execute can redirect any thread's PC.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-high
//     bus   : barrel_thread_sched_if.slave (enables, redirects, issue, writeback)
//   Optional feature macro: BARREL_THREAD_HALT_EN adds per-thread halt/resume.
module barrel_thread_sched #(
    parameter int unsigned           NUM_THREADS = 8,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           PIPE_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input logic                  clk,
    input logic                  reset,
    barrel_thread_sched_if.slave bus
);
    localparam int unsigned TW = $clog2(NUM_THREADS);

    logic [ADDR_WIDTH-1:0]  r_pc [NUM_THREADS];
    logic [TW-1:0]          r_ptr;
    logic                   r_issue_valid;
    logic [TW-1:0]          r_issue_tid;
    logic [ADDR_WIDTH-1:0]  r_issue_pc;
    logic [PIPE_DEPTH-1:0]  r_wb_valid;
    logic [TW-1:0]          r_wb_tid [PIPE_DEPTH];

    logic [NUM_THREADS-1:0] w_halted;
    logic [NUM_THREADS-1:0] w_mask;
    logic                   w_any;
    logic [TW-1:0]          w_sel;
    logic [TW-1:0]          w_cand;

`ifdef BARREL_THREAD_HALT_EN
    logic [NUM_THREADS-1:0] r_halted;

    // Halt is checked first so it wins over a resume of the same thread.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_halted <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                if (bus.halt_valid && bus.halt_tid == TW'(i))
                    r_halted[i] <= 1'b1;
                else if (bus.resume_valid && bus.resume_tid == TW'(i))
                    r_halted[i] <= 1'b0;
            end
        end
    end

    assign w_halted = r_halted;
`else
    assign w_halted = '0;
`endif

    assign w_mask = bus.thread_en & ~w_halted;
    assign w_any  = |w_mask;

    // Scan offsets from NUM_THREADS down to 1 so the last hit is the smallest
    // offset; offset NUM_THREADS wraps to r_ptr itself (single-runnable case).
    always_comb begin
        w_sel  = r_ptr;
        w_cand = r_ptr;
        for (int unsigned k = NUM_THREADS; k >= 1; k--) begin
            w_cand = r_ptr + TW'(k);
            if (w_mask[w_cand])
                w_sel = w_cand;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issue_valid <= 1'b0;
            r_issue_tid   <= '0;
            r_issue_pc    <= '0;
            r_ptr         <= TW'(NUM_THREADS - 1);
        end else begin
            r_issue_valid <= w_any;
            if (w_any) begin
                r_issue_tid <= w_sel;
                r_issue_pc  <= r_pc[w_sel];
                r_ptr       <= w_sel;
            end
        end
    end

    // A redirect to the thread issuing on the same edge replaces its +4.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_THREADS; i++)
                r_pc[i] <= RESET_PC;
        end else begin
            for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                if (bus.redirect_valid && bus.redirect_tid == TW'(i))
                    r_pc[i] <= bus.redirect_pc;
                else if (w_any && w_sel == TW'(i))
                    r_pc[i] <= r_pc[i] + ADDR_WIDTH'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_valid <= '0;
            for (int unsigned j = 0; j < PIPE_DEPTH; j++)
                r_wb_tid[j] <= '0;
        end else begin
            r_wb_valid[0] <= r_issue_valid;
            r_wb_tid[0]   <= r_issue_tid;
            for (int unsigned j = 1; j < PIPE_DEPTH; j++) begin
                r_wb_valid[j] <= r_wb_valid[j-1];
                r_wb_tid[j]   <= r_wb_tid[j-1];
            end
        end
    end

    assign bus.issue_valid = r_issue_valid;
    assign bus.issue_tid   = r_issue_tid;
    assign bus.issue_pc    = r_issue_pc;
    assign bus.tid_read    = r_issue_tid;
    assign bus.tid_write   = r_wb_tid[PIPE_DEPTH-1];
    assign bus.wb_valid    = r_wb_valid[PIPE_DEPTH-1];
    assign bus.active_mask = w_mask;
endmodule

// File: tb/tb_barrel_thread_sched.sv
// tb_barrel_thread_sched
//   Directed stimulus with hand-computed expected issue/writeback streams.
module tb_barrel_thread_sched;
    localparam int unsigned NT = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned PD = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    barrel_thread_sched_if #(.NUM_THREADS(NT), .ADDR_WIDTH(AW)) bus_if ();

    barrel_thread_sched #(
        .NUM_THREADS(NT),
        .ADDR_WIDTH (AW),
        .PIPE_DEPTH (PD),
        .RESET_PC   (32'h0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  tid;
        logic [31:0] pc;
    } exp_t;

    exp_t       exp_issue[$];
    logic [2:0] exp_wb[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         first_issue = -1;
    int         first_wb    = -1;
    exp_t       e;
    logic [2:0] wt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: pops expected entries whenever the DUT presents an issue or writeback.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_if.issue_valid) begin
                if (first_issue < 0) first_issue = cyc;
                total++;
                if (exp_issue.size() == 0) begin
                    bad++;
                    $display("FAIL issue_unexpected: got tid=%0d pc=%h, required no issue",
                             bus_if.issue_tid, bus_if.issue_pc);
                end else begin
                    e = exp_issue.pop_front();
                    if (bus_if.issue_tid !== e.tid || bus_if.issue_pc !== e.pc ||
                        bus_if.tid_read !== e.tid) begin
                        bad++;
                        $display("FAIL issue: got tid=%0d rd=%0d pc=%h, required tid=%0d pc=%h",
                                 bus_if.issue_tid, bus_if.tid_read, bus_if.issue_pc, e.tid, e.pc);
                    end
                end
            end
            if (bus_if.wb_valid) begin
                if (first_wb < 0) begin
                    first_wb = cyc;
                    total++;
                    if (first_wb - first_issue != int'(PD)) begin
                        bad++;
                        $display("FAIL wb_latency: got %0d, required %0d", first_wb - first_issue, PD);
                    end
                end
                total++;
                if (exp_wb.size() == 0) begin
                    bad++;
                    $display("FAIL wb_unexpected: got tid_write=%0d, required no writeback", bus_if.tid_write);
                end else begin
                    wt = exp_wb.pop_front();
                    if (bus_if.tid_write !== wt) begin
                        bad++;
                        $display("FAIL tid_write: got %0d, required %0d", bus_if.tid_write, wt);
                    end
                end
            end
        end
    end

    // One cycle: drive inputs, push the expected issue for the coming edge.
    task automatic step(input logic [7:0] en, input logic v, input logic [2:0] tid, input logic [31:0] pc);
        bus_if.thread_en = en;
        if (v) begin
            exp_issue.push_back({tid, pc});
            exp_wb.push_back(tid);
        end
        @(posedge clk);
        #2;
        if (!v) chk("idle_issue_valid", 64'(bus_if.issue_valid), 64'd0);
        bus_if.redirect_valid = 1'b0;
`ifdef BARREL_THREAD_HALT_EN
        bus_if.halt_valid   = 1'b0;
        bus_if.resume_valid = 1'b0;
`endif
    endtask

    int t3_tid[6] = '{6, 7, 0, 1, 2, 3};
    int t3_pc [6] = '{8, 8, 12, 8, 20, 8};
    int t4_tid[22] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6};
    int t4_pc [22] = '{12, 24, 12, 12, 'h100, 16, 16, 20, 16, 28, 16, 16, 'h104,
                       20, 20, 24, 20, 32, 20, 20, 'h108, 'h200};
`ifdef BARREL_THREAD_HALT_EN
    int th_tid[21] = '{3, 5, 6, 7, 0, 1, 2, 3, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7, 0, 2};
    int th_pc [21] = '{0, 0, 0, 0, 4, 4, 4, 4, 4, 4, 4, 8, 8, 8, 8, 0, 8, 8, 8, 12, 12};
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.thread_en      = '0;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_tid   = '0;
        bus_if.redirect_pc    = '0;
`ifdef BARREL_THREAD_HALT_EN
        bus_if.halt_valid   = 1'b0;
        bus_if.halt_tid     = '0;
        bus_if.resume_valid = 1'b0;
        bus_if.resume_tid   = '0;
`endif
        repeat (2) @(posedge clk);
        #2;
        chk("rst_issue_valid", 64'(bus_if.issue_valid), 64'd0);
        chk("rst_issue_tid",   64'(bus_if.issue_tid),   64'd0);
        chk("rst_issue_pc",    64'(bus_if.issue_pc),    64'd0);
        chk("rst_tid_read",    64'(bus_if.tid_read),    64'd0);
        chk("rst_tid_write",   64'(bus_if.tid_write),   64'd0);
        chk("rst_wb_valid",    64'(bus_if.wb_valid),    64'd0);
        reset = 1'b0;

        // All enabled: 0..7 at pc 0, 0..7 at pc 4, then 0 at pc 8.
        for (int i = 0; i < 17; i++)
            step(8'hFF, 1'b1, 3'(i % 8), 32'(4 * (i / 8)));

        // Two runnable threads alternate.
        for (int i = 0; i < 6; i++)
            step(8'h24, 1'b1, (i % 2 == 0) ? 3'd2 : 3'd5, 32'(8 + 4 * (i / 2)));
        chk("active_mask", 64'(bus_if.active_mask), 64'h24);

        // Issue through tid 3, go idle 3 cycles, resume at tid 4.
        for (int i = 0; i < 6; i++)
            step(8'hFF, 1'b1, 3'(t3_tid[i]), 32'(t3_pc[i]));
        for (int i = 0; i < 3; i++)
            step(8'h00, 1'b0, 3'd0, 32'd0);
        step(8'hFF, 1'b1, 3'd4, 32'd8);
        step(8'hFF, 1'b1, 3'd5, 32'd20);
        step(8'hFF, 1'b1, 3'd6, 32'd12);
        step(8'hFF, 1'b1, 3'd7, 32'd12);
        step(8'hFF, 1'b1, 3'd0, 32'd16);

        // Redirect tid 5 one cycle ahead; redirect tid 6 on its own issue edge.
        for (int i = 0; i < 22; i++) begin
            if (i == 3) begin
                bus_if.redirect_valid = 1'b1;
                bus_if.redirect_tid   = 3'd5;
                bus_if.redirect_pc    = 32'h100;
            end else if (i == 13) begin
                bus_if.redirect_valid = 1'b1;
                bus_if.redirect_tid   = 3'd6;
                bus_if.redirect_pc    = 32'h200;
            end
            step(8'hFF, 1'b1, 3'(t4_tid[i]), 32'(t4_pc[i]));
        end

        // Single runnable thread reselects itself.
        step(8'h08, 1'b1, 3'd3, 32'd24);
        step(8'h08, 1'b1, 3'd3, 32'd28);

        // Mid-run reset discards in-flight writebacks.
        step(8'hFF, 1'b1, 3'd4, 32'd24);
        step(8'hFF, 1'b1, 3'd5, 32'h10C);
        chk("pre_rst_wb_valid", 64'(bus_if.wb_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_wb_valid",    64'(bus_if.wb_valid),    64'd0);
        chk("mid_rst_issue_valid", 64'(bus_if.issue_valid), 64'd0);
        chk("mid_rst_issue_pc",    64'(bus_if.issue_pc),    64'd0);
        chk("mid_rst_tid_write",   64'(bus_if.tid_write),   64'd0);
        exp_issue.delete();
        exp_wb.delete();
        first_issue = -1;
        first_wb    = -1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        step(8'hFF, 1'b1, 3'd0, 32'd0);
        step(8'hFF, 1'b1, 3'd1, 32'd0);
        step(8'hFF, 1'b1, 3'd2, 32'd0);

`ifdef BARREL_THREAD_HALT_EN
        // Halt tid 4, resume it, then halt+resume tid 1 on one edge (halt wins).
        for (int i = 0; i < 21; i++) begin
            if (i == 0) begin
                bus_if.halt_valid = 1'b1;
                bus_if.halt_tid   = 3'd4;
            end else if (i == 8) begin
                bus_if.resume_valid = 1'b1;
                bus_if.resume_tid   = 3'd4;
            end else if (i == 16) begin
                bus_if.halt_valid   = 1'b1;
                bus_if.halt_tid     = 3'd1;
                bus_if.resume_valid = 1'b1;
                bus_if.resume_tid   = 3'd1;
            end
            step(8'hFF, 1'b1, 3'(th_tid[i]), 32'(th_pc[i]));
            if (i == 2) chk("halt_active_mask", 64'(bus_if.active_mask), 64'hEF);
        end
`endif

        for (int i = 0; i < 6; i++)
            step(8'h00, 1'b0, 3'd0, 32'd0);
        chk("issue_queue_empty", 64'(exp_issue.size()), 64'd0);
        chk("wb_queue_empty",    64'(exp_wb.size()),    64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/barrel_thread_sched.md
# barrel_thread_sched

Upstream thread scheduler for the barrel core: each cycle it picks the next runnable hardware thread round-robin and issues that thread's PC to fetch. It drives `tid_read` into the multithreaded register file and the delayed `tid_write`/`wb_valid` pair used at writeback. It holds one PC per thread, advances it on issue, and accepts branch/jump redirects from execute.

## Interface
- `NUM_THREADS`, 8: hardware threads; power of two, ≥2.
- `ADDR_WIDTH`, 32: PC width.
- `PIPE_DEPTH`, 4: cycles from issue to writeback; ≥1, ≤ NUM_THREADS.
- `RESET_PC`, 0: reset value of every thread PC.

Ports (`TW` = $clog2(NUM_THREADS)):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `thread_en` in NUM_THREADS: per-thread runnable mask, sampled every cycle.
- `redirect_valid` in 1: PC redirect request.
- `redirect_tid` in TW: thread to redirect.
- `redirect_pc` in ADDR_WIDTH: new PC.
- `issue_valid` out 1: fetch slot holds a valid thread.
- `issue_tid` out TW: issued thread.
- `issue_pc` out ADDR_WIDTH: issued PC.
- `tid_read` out TW: equals `issue_tid`, goes to register-file read thread select.
- `tid_write` out TW: `issue_tid` delayed PIPE_DEPTH cycles.
- `wb_valid` out 1: `issue_valid` delayed PIPE_DEPTH cycles.
- `active_mask` out NUM_THREADS: effective runnable mask (`thread_en` AND ~halted).

## Operation
- State: `pc[NUM_THREADS]`, round-robin pointer `ptr` (TW bits), PIPE_DEPTH-entry {valid,tid} shift register, `halted` vector (macro only).
- Selection: effective mask `m = active_mask`. Smallest k in 1..NUM_THREADS with `m[(ptr+k) mod NUM_THREADS]` set. Selected thread `s = (ptr+k) mod NUM_THREADS`. k = NUM_THREADS reselects the same thread, which covers the single-runnable case.
- If m ≠ 0:
  - `issue_valid<=1`, `issue_tid<=s`, `issue_pc<=pc[s]`.
  - `pc[s]<=pc[s]+4` (wraps mod 2^ADDR_WIDTH).
  - `ptr<=s`.
- If m = 0: `issue_valid<=0`; `issue_tid`, `issue_pc` and `ptr` hold.
- Redirect: when `redirect_valid`, `pc[redirect_tid]<=redirect_pc`.
  - If same edge issues `s==redirect_tid`, `issue_pc` takes the old `pc[s]` and the redirect overrides the +4.
  - No squash is performed; with PIPE_DEPTH ≤ NUM_THREADS and all threads running, no same-thread instruction is in flight.
- Writeback pipe: stage0 <= {issue_valid, issue_tid} (registered values); `tid_write`/`wb_valid` = last stage.
- `tid_read` is combinational from the `issue_tid` register. The register file snapshots that thread on the next edge.

## Timing
- Reset (async assert) values:
  - `issue_valid=0`, `issue_tid=0`, `issue_pc=0`, `tid_read=0`.
  - `tid_write=0`, `wb_valid=0`, all pipe stages {0,0}.
  - all `pc=RESET_PC`, `ptr=NUM_THREADS-1`, `halted=0`.
- First rising edge after reset release with all threads enabled issues thread 0.
- Issue latency: 1 cycle from `thread_en` or redirect change to its effect on `issue_*`.
- Throughput: one issue per cycle while m ≠ 0.
- `wb_valid`/`tid_write` at cycle t equal `issue_valid`/`issue_tid` at cycle t−PIPE_DEPTH.
- Reset mid-operation: all state returns to reset values immediately. In-flight pipe entries are discarded (`wb_valid=0`).
- `thread_en` bit cleared for a thread already issued: in-flight entries still retire through the pipe.

## Configuration
- `BARREL_THREAD_HALT_EN` defined:
  - Adds inputs `halt_valid` (1) and `halt_tid` (TW), plus `resume_valid` (1) and `resume_tid` (TW).
  - `halt_valid` sets `halted[halt_tid]` at the edge; `resume_valid` clears `resume_tid`'s bit.
  - If both name the same tid on the same edge, halt wins.
  - The halt takes effect on selection from the next cycle.
- Undefined: these ports are absent, `halted` is constant 0, and `active_mask = thread_en`.

## Test plan
- Reset, `thread_en=8'hFF`: `issue_tid` 0,1,…,7,0; first round `issue_pc=0`, second round 4, third round 8.
- `thread_en=8'b0010_0100`: `issue_tid` 2,5,2,5,…; each thread's PC steps by 4 per issue.
- `thread_en=0` for 3 cycles after issuing tid 3, then 8'hFF: `issue_valid=0` for 3 cycles, then resumes at tid 4.
- All enabled, redirect tid 5 to 32'h100 one cycle before tid 5 issues: tid 5 issues `issue_pc=32'h100`, and its next issue is 32'h104.
- PIPE_DEPTH=4, all enabled: `wb_valid` rises 4 cycles after `issue_valid`; `tid_write` sequence equals `issue_tid` shifted 4 cycles. Assert reset mid-run: `wb_valid` goes to 0 immediately.
- With `BARREL_THREAD_HALT_EN`, halt tid 1: sequence skips 1 (0,2,3,…). Resume tid 1: it reappears in order.
